// File: rtl/uartlite_axil_regs.sv
// uartlite_axil_regs: AXI4-Lite slave register block for a UART-lite style serial PHY.
//
// Address map (word aligned, awaddr/araddr bits [1:0] ignored):
//   0x0 RX   read pops one byte from the RX FIFO (0 when empty); writes ignored
//   0x4 TX   write pushes wdata[7:0] when wstrb[0]; reads return 0
//   0x8 STAT read {overrun, int_en, tx_full, tx_empty, rx_full, rx_valid}; read clears overrun
//   0xC CTRL write (wstrb[0]): [0] flush TX, [1] flush RX, [4] int_en; reads return 0
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   aw*/w*/b*              AXI4-Lite write address, data and response channels
//   ar*/r*                 AXI4-Lite read address and data channels
//   tx_data_o/tx_valid_o   head of the TX FIFO towards the PHY, popped on tx_ready_i
//   rx_data_i/rx_valid_i   one-cycle byte strobe from the PHY, no backpressure
//   irq_o                  registered int_en & (rx_valid | tx_empty)
module uartlite_axil_regs #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PTR_W      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    input  logic [3:0]  araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        irq_o
);

    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] AddrRx   = 2'd0;
    localparam logic [1:0] AddrTx   = 2'd1;
    localparam logic [1:0] AddrStat = 2'd2;
    localparam logic [1:0] AddrCtrl = 2'd3;

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    logic       awready_q, awready_d;
    logic       wready_q, wready_d;
    logic       aw_held_q, aw_held_d;
    logic       w_held_q, w_held_d;
    logic [1:0] aw_addr_q, aw_addr_d;
    logic [7:0] w_data_q, w_data_d;
    logic       w_strb0_q, w_strb0_d;
    logic       bvalid_q, bvalid_d;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    logic       arready_q, arready_d;
    logic       rvalid_q, rvalid_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] rd_mux;

    // ------------------------------------------------------------------
    // FIFOs and control state
    // ------------------------------------------------------------------
    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PTR_W-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PTR_W:0]   tx_count_q, tx_count_d;

    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PTR_W-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [PTR_W:0]   rx_count_q, rx_count_d;

    logic overrun_q, overrun_d;
    logic int_en_q, int_en_d;
    logic irq_q, irq_d;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic wr_fire, wr_tx, wr_ctrl;
    logic ar_hs, rd_rx_pop, rd_stat;
    logic tx_empty, tx_full, tx_pop, tx_push, tx_flush;
    logic rx_nempty, rx_full, rx_push, rx_ovf, rx_flush;

    // Address LSBs and upper data/strobe bits carry no meaning in this block.
    logic unused_ok;
    assign unused_ok = ^{awaddr_i[1:0], araddr_i[1:0], wdata_i[31:8], wstrb_i[3:1]};

    assign tx_empty  = (tx_count_q == '0);
    assign tx_full   = (tx_count_q == FullCnt);
    assign rx_nempty = (rx_count_q != '0);
    assign rx_full   = (rx_count_q == FullCnt);

    // The write takes effect one edge after both address and data are held.
    assign wr_fire = aw_held_q & w_held_q & ~bvalid_q;
    assign wr_tx   = wr_fire & (aw_addr_q == AddrTx) & w_strb0_q;
    assign wr_ctrl = wr_fire & (aw_addr_q == AddrCtrl) & w_strb0_q;

    assign ar_hs     = arvalid_i & arready_q;
    assign rd_rx_pop = ar_hs & (araddr_i[3:2] == AddrRx) & rx_nempty;
    assign rd_stat   = ar_hs & (araddr_i[3:2] == AddrStat);

    assign tx_pop   = ~tx_empty & tx_ready_i;
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign tx_push  = wr_tx & (~tx_full | tx_pop);
    assign tx_flush = wr_ctrl & w_data_q[0];

    assign rx_push  = rx_valid_i & (~rx_full | rd_rx_pop);
    assign rx_ovf   = rx_valid_i & rx_full & ~rd_rx_pop;
    assign rx_flush = wr_ctrl & w_data_q[1];

    // ------------------------------------------------------------------
    // Write channel next state
    // ------------------------------------------------------------------
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb0_d = w_strb0_q;
        bvalid_d  = bvalid_q;

        if (awvalid_i && awready_q) begin
            aw_held_d = 1'b1;
            aw_addr_d = awaddr_i[3:2];
        end
        if (wvalid_i && wready_q) begin
            w_held_d  = 1'b1;
            w_data_d  = wdata_i[7:0];
            w_strb0_d = wstrb_i[0];
        end

        if (wr_fire) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else if (bvalid_q && bready_i) begin
            bvalid_d = 1'b0;
        end

        // Ready whenever nothing is captured and no response is pending; this also
        // raises the readys on the first edge after reset.
        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
    end

    // ------------------------------------------------------------------
    // Read channel next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = 8'h00;
        case (araddr_i[3:2])
            AddrRx: begin
                if (rx_nempty) begin
                    rd_mux = rx_mem_q[rx_rd_ptr_q];
                end
            end
            AddrStat: rd_mux = {2'b00, overrun_q, int_en_q, tx_full, tx_empty, rx_full, rx_nempty};
            default:  rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
        end
        arready_d = ~rvalid_d;
    end

    // ------------------------------------------------------------------
    // FIFO pointer/count next state; flush overrides push and pop
    // ------------------------------------------------------------------
    always_comb begin
        if (tx_flush) begin
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_count_d  = '0;
        end else begin
            tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(tx_push);
            tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(tx_pop);
            tx_count_d  = tx_count_q + (PTR_W + 1)'(tx_push) - (PTR_W + 1)'(tx_pop);
        end
    end

    always_comb begin
        if (rx_flush) begin
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_count_d  = '0;
        end else begin
            rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(rx_push);
            rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(rd_rx_pop);
            rx_count_d  = rx_count_q + (PTR_W + 1)'(rx_push) - (PTR_W + 1)'(rd_rx_pop);
        end
    end

    // ------------------------------------------------------------------
    // Control, status and interrupt next state
    // ------------------------------------------------------------------
    always_comb begin
        overrun_d = overrun_q;
        int_en_d  = int_en_q;
        // A new overrun in the same cycle as the clearing read must not be lost.
        if (rd_stat) begin
            overrun_d = 1'b0;
        end
        if (rx_ovf) begin
            overrun_d = 1'b1;
        end
        if (wr_ctrl) begin
            int_en_d = w_data_q[4];
        end
        irq_d = int_en_q & (rx_nempty | tx_empty);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            aw_addr_q   <= 2'b00;
            w_data_q    <= 8'h00;
            w_strb0_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 8'h00;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            overrun_q   <= 1'b0;
            int_en_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb0_q   <= w_strb0_d;
            bvalid_q    <= bvalid_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
            overrun_q   <= overrun_d;
            int_en_q    <= int_en_d;
            irq_q       <= irq_d;
        end
    end

    // Storage needs no reset: the counts gate every read of it.
    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= w_data_q;
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= rx_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign awready_o  = awready_q;
    assign wready_o   = wready_q;
    assign bresp_o    = 2'b00;
    assign bvalid_o   = bvalid_q;
    assign arready_o  = arready_q;
    assign rdata_o    = {24'h000000, rdata_q};
    assign rresp_o    = 2'b00;
    assign rvalid_o   = rvalid_q;
    assign tx_valid_o = ~tx_empty;
    assign tx_data_o  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_uartlite_axil_regs.sv
// Self-checking bench for uartlite_axil_regs: directed scenarios followed by randomized bus and
// PHY traffic, all compared against a queue-based reference model of the register map.
module tb_uartlite_axil_regs;

    logic        clk;
    logic        rst;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Reference model: FIFO contents as queues plus the two control bits.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_overrun;
    logic       m_int_en;

    uartlite_axil_regs dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .awaddr_i   (awaddr),
        .awvalid_i  (awvalid),
        .awready_o  (awready),
        .wdata_i    (wdata),
        .wstrb_i    (wstrb),
        .wvalid_i   (wvalid),
        .wready_o   (wready),
        .bresp_o    (bresp),
        .bvalid_o   (bvalid),
        .bready_i   (bready),
        .araddr_i   (araddr),
        .arvalid_i  (arvalid),
        .arready_o  (arready),
        .rdata_o    (rdata),
        .rresp_o    (rresp),
        .rvalid_o   (rvalid),
        .rready_i   (rready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already set for the next rising edge. Any TX pop
    // that edge will perform is checked against the model before time advances.
    task automatic step();
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                check("tx_unexpected_byte", 32'(tx_valid), 32'd0);
            end else begin
                check("tx_data_order", 32'(tx_data), 32'(tx_q.pop_front()));
            end
        end
        @(negedge clk);
    endtask

    function automatic void model_reset();
        tx_q.delete();
        rx_q.delete();
        m_overrun = 1'b0;
        m_int_en  = 1'b0;
    endfunction

    function automatic void model_rx_push(input logic [7:0] b);
        if (rx_q.size() < 16) rx_q.push_back(b);
        else m_overrun = 1'b1;
    endfunction

    // Applied just before the edge on which the write takes effect.
    function automatic void model_write(input logic [3:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        if (strb[0]) begin
            if (addr[3:2] == 2'd1) begin
                if (tx_q.size() < 16 || (tx_q.size() > 0 && tx_ready)) tx_q.push_back(data[7:0]);
            end else if (addr[3:2] == 2'd3) begin
                if (data[0]) tx_q.delete();
                if (data[1]) rx_q.delete();
                m_int_en = data[4];
            end
        end
    endfunction

    // Applied just before the edge on which the read address is accepted.
    function automatic logic [31:0] model_read(input logic [3:0] addr);
        logic [31:0] v;
        v = 32'd0;
        if (addr[3:2] == 2'd0) begin
            if (rx_q.size() > 0) v = 32'(rx_q.pop_front());
        end else if (addr[3:2] == 2'd2) begin
            v = {26'd0, m_overrun, m_int_en, tx_q.size() == 16, tx_q.size() == 0,
                 rx_q.size() == 16, rx_q.size() != 0};
            m_overrun = 1'b0;
        end
        return v;
    endfunction

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_delay, input int b_delay);
        bit aw_done;
        bit w_done;
        bit aw_hs;
        bit w_hs;
        int w_left;
        int c;
        aw_done = 0;
        w_done  = 0;
        w_left  = w_delay;
        c       = 0;
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = (w_delay == 0);
        while (!(aw_done && w_done) && c < 100) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            c++;
            if (aw_hs) begin
                awvalid = 1'b0;
                aw_done = 1;
            end
            if (w_hs) begin
                wvalid = 1'b0;
                w_done = 1;
            end
            if (!wvalid && !w_done) begin
                if (w_left > 0) w_left--;
                if (w_left == 0) wvalid = 1'b1;
            end
            if (aw_done && !w_done) check("no_b_before_w", 32'(bvalid), 32'd0);
        end
        check("wr_handshakes", 32'(aw_done && w_done), 32'd1);
        model_write(addr, data, strb);
        step();
        check("b_latency", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
        for (int i = 0; i < b_delay; i++) begin
            step();
            check("b_hold", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("b_done", 32'(bvalid), 32'd0);
        check("aw_ready_back", 32'(awready), 32'd1);
        check("w_ready_back", 32'(wready), 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_delay, input bit inj,
                            input logic [7:0] inj_b, output logic [31:0] data);
        logic [31:0] exp;
        bit hs;
        hs      = 0;
        araddr  = addr;
        arvalid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (arready) begin
                hs = 1;
                break;
            end
            step();
        end
        check("ar_handshake", 32'(hs), 32'd1);
        exp = model_read(addr);
        if (inj) begin
            rx_valid = 1'b1;
            rx_data  = inj_b;
            model_rx_push(inj_b);
        end
        step();
        arvalid  = 1'b0;
        rx_valid = 1'b0;
        check("rvalid", 32'(rvalid), 32'd1);
        check("rdata", rdata, exp);
        check("rresp", 32'(rresp), 32'd0);
        check("ar_busy", 32'(arready), 32'd0);
        for (int i = 0; i < r_delay; i++) begin
            step();
            check("r_hold", 32'(rvalid), 32'd1);
            check("r_stable", rdata, exp);
        end
        data   = rdata;
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("r_done", 32'(rvalid), 32'd0);
        check("ar_ready_back", 32'(arready), 32'd1);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        model_rx_push(b);
        step();
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] cdata;
        logic [3:0]  a;
        int op;

        rst      = 1'b1;
        awaddr   = 4'h0;
        awvalid  = 1'b0;
        wdata    = 32'h0;
        wstrb    = 4'h0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        araddr   = 4'h0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        model_reset();

        // Reset state
        #3;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("release_arready", 32'(arready), 32'd0);
        step();
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_wready", 32'(wready), 32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);

        // 1: single TX byte straight through to the PHY
        tx_ready = 1'b1;
        axi_write(4'h4, 32'h41, 4'h1, 0, 0);
        step();
        step();
        check("t1_tx_empty", 32'(tx_valid), 32'd0);
        axi_read(4'h8, 0, 0, 8'h00, d);
        check("t1_stat", d, 32'h04);

        // 2: one received byte
        rx_byte(8'h5A);
        axi_read(4'h8, 1, 0, 8'h00, d);
        check("t2_stat_valid", d, 32'h05);
        axi_read(4'h0, 0, 0, 8'h00, d);
        check("t2_rx_byte", d, 32'h5A);
        axi_read(4'h8, 0, 0, 8'h00, d);
        check("t2_stat_empty", d, 32'h04);

        // 3: TX full, dropped 17th byte, ordered drain
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) axi_write(4'h4, 32'(i), 4'h1, 0, 0);
        axi_read(4'h8, 0, 0, 8'h00, d);
        check("t3_tx_full", 32'(d[3]), 32'd1);
        axi_write(4'h4, 32'hFF, 4'h1, 0, 0);
        axi_read(4'h8, 0, 0, 8'h00, d);
        check("t3_stat_full", d, 32'h08);
        tx_ready = 1'b1;
        repeat (20) step();
        check("t3_drained", 32'(tx_valid), 32'd0);

        // 4: RX overrun
        for (int i = 0; i < 17; i++) rx_byte(8'(8'h80 + i));
        axi_read(4'h8, 0, 0, 8'h00, d);
        check("t4_stat_overrun", d, 32'h27);
        axi_read(4'h8, 0, 0, 8'h00, d);
        check("t4_stat_cleared", d, 32'h07);
        for (int i = 0; i < 16; i++) begin
            axi_read(4'h0, 0, 0, 8'h00, d);
            check("t4_rx_byte", d, 32'(8'h80 + i));
        end
        axi_read(4'h0, 0, 0, 8'h00, d);
        check("t4_rx_empty_read", d, 32'h00);

        // RX full with a same-cycle pop accepts the new byte, then flush RX
        for (int i = 0; i < 16; i++) rx_byte(8'(8'h10 + i));
        axi_read(4'h0, 0, 1, 8'hC3, d);
        check("full_pop_byte", d, 32'h10);
        axi_read(4'h8, 0, 0, 8'h00, d);
        check("full_pop_no_overrun", d, 32'h07);
        axi_write(4'hC, 32'h02, 4'h1, 0, 0);
        axi_read(4'h8, 0, 0, 8'h00, d);
        check("rx_flushed", d, 32'h04);

        // 5: AW three cycles ahead of W, response held off two cycles
        tx_ready = 1'b0;
        axi_write(4'h4, 32'h77, 4'h1, 3, 2);
        step();
        check("t5_tx_valid", 32'(tx_valid), 32'd1);
        check("t5_tx_data", 32'(tx_data), 32'h77);
        axi_write(4'hC, 32'h01, 4'h1, 0, 0);
        step();
        check("t5_tx_flushed", 32'(tx_valid), 32'd0);

        // Interrupt
        axi_write(4'hC, 32'h10, 4'h1, 0, 0);
        step();
        step();
        check("irq_tx_empty", 32'(irq), 32'd1);
        axi_write(4'h4, 32'h55, 4'h1, 0, 0);
        step();
        step();
        check("irq_tx_busy", 32'(irq), 32'd0);
        rx_byte(8'h66);
        step();
        step();
        check("irq_rx_valid", 32'(irq), 32'd1);
        axi_read(4'h0, 0, 0, 8'h00, d);
        tx_ready = 1'b1;

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            op = int'($urandom_range(0, 8));
            case (op)
                0, 1: axi_write(4'h4, $urandom, ($urandom_range(0, 5) != 0) ? 4'hF : 4'hE,
                                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                2: axi_read(4'h0, int'($urandom_range(0, 2)), 0, 8'h00, d);
                3: begin
                    a = {2'($urandom_range(1, 3)), 2'($urandom_range(0, 3))};
                    axi_read(a, 0, 0, 8'h00, d);
                end
                4, 5: rx_byte(8'($urandom));
                6: begin
                    a = {2'($urandom_range(0, 3)), 2'b00};
                    cdata = $urandom;
                    if (a[3:2] == 2'd3) begin
                        cdata = cdata & 32'h13;
                        if (tx_ready) cdata[0] = 1'b0;
                    end
                    if (a[3:2] != 2'd1) axi_write(a, cdata, 4'($urandom), 0, 0);
                end
                7: tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!tx_ready || tx_q.size() == 0) begin
                        step();
                        step();
                        check("rand_irq", 32'(irq),
                              32'(m_int_en && (rx_q.size() != 0 || tx_q.size() == 0)));
                        check("rand_tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
                    end
                end
            endcase
        end
        tx_ready = 1'b1;
        repeat (20) step();
        check("rand_tx_drained", 32'(tx_valid), 32'd0);

        // 6: reset in the middle of a read with bytes queued
        tx_ready = 1'b0;
        axi_write(4'h4, 32'h99, 4'h1, 0, 0);
        rx_byte(8'h11);
        araddr  = 4'h8;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check("t6_rvalid_before", 32'(rvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rvalid_async", 32'(rvalid), 32'd0);
        check("t6_tx_valid", 32'(tx_valid), 32'd0);
        check("t6_arready", 32'(arready), 32'd0);
        check("t6_awready", 32'(awready), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        check("t6_awready_back", 32'(awready), 32'd1);
        check("t6_wready_back", 32'(wready), 32'd1);
        check("t6_arready_back", 32'(arready), 32'd1);
        axi_read(4'h8, 0, 0, 8'h00, d);
        check("t6_stat", d, 32'h04);
        axi_read(4'h0, 0, 0, 8'h00, d);
        check("t6_rx_empty", d, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
